// File: rtl/key_pkg.sv
// Shared constants and types for the push-button conditioning path.
// Default timing assumes the 50 MHz system clock of the clock/stopwatch/timer core.
package key_pkg;

  localparam int DEF_N_KEYS              = 4;
  localparam int DEF_DEBOUNCE_CYCLES     = 1_000_000;   // 20 ms
  localparam int DEF_REPEAT_DELAY_CYCLES = 25_000_000;  // 500 ms
  localparam int DEF_REPEAT_RATE_CYCLES  = 5_000_000;   // 100 ms
  localparam int DEF_CNT_W               = 26;

  // Board key roles as seen by the mode and increment controls.
  localparam int KEY_INC_MINUTES = 1;
  localparam int KEY_INC_HOURS   = 2;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } rpt_state_e;

endpackage

// File: rtl/key_channel.sv
// One key: 2-flop synchroniser, debounce filter, press/release pulses and
// an auto-repeat FSM that adds action pulses while the key stays held.
module key_channel
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES,
  parameter int CNT_W               = DEF_CNT_W
) (
  input  logic clk_50MHz,
  input  logic reset_n,
  input  logic key_n,
  input  logic repeat_en,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_act
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] RR_LAST  = CNT_W'(REPEAT_RATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic             s1;
  logic             s2;
  logic             stable;
  logic [CNT_W-1:0] dcnt;
  logic [CNT_W-1:0] rcnt;
  rpt_state_e       state;

  // key_level lags stable by one cycle, so a difference marks an accepted edge.
  logic press_evt;
  logic release_evt;
  assign press_evt   = stable & ~key_level;
  assign release_evt = ~stable & key_level;

  // NOTE: non-blocking assignments make s1->s2 a true two-stage shift; blocking
  // ones would collapse the synchroniser into a single flop.
  always_ff @(posedge clk_50MHz) begin
    if (!reset_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      dcnt   <= CNT_ZERO;
    end else begin
      s1 <= ~key_n;
      s2 <= s1;
      if (s2 == stable) begin
        dcnt <= CNT_ZERO;
      end else if (dcnt == DB_LAST) begin
        stable <= s2;
        dcnt   <= CNT_ZERO;
      end else begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (!reset_n) begin
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      key_level   <= stable;
      key_press   <= press_evt;
      key_release <= release_evt;
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (!reset_n) begin
      state   <= IDLE;
      rcnt    <= CNT_ZERO;
      key_act <= 1'b0;
    end else begin
      // NOTE: the default makes key_act a one-cycle pulse; each branch only raises it.
      key_act <= 1'b0;
      if (release_evt) begin
        state <= IDLE;
        rcnt  <= CNT_ZERO;
      end else begin
        case (state)
          IDLE: begin
            if (press_evt) begin
              state   <= DELAY;
              rcnt    <= CNT_ZERO;
              key_act <= 1'b1;
            end
          end
          DELAY: begin
            if (!repeat_en) begin
              rcnt <= CNT_ZERO;
            end else if (rcnt == RD_LAST) begin
              state   <= REPEAT;
              rcnt    <= CNT_ZERO;
              key_act <= 1'b1;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
          REPEAT: begin
            // Losing the enable restarts the full initial delay once it returns.
            if (!repeat_en) begin
              state <= DELAY;
              rcnt  <= CNT_ZERO;
            end else if (rcnt == RR_LAST) begin
              rcnt    <= CNT_ZERO;
              key_act <= 1'b1;
            end else begin
              rcnt <= rcnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            rcnt  <= CNT_ZERO;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/key_conditioner.sv
// Conditions the raw active-low DE2 push-buttons into debounced levels and
// single-cycle press/release/action pulses, one independent channel per key.
module key_conditioner
  import key_pkg::*;
#(
  parameter int N_KEYS              = DEF_N_KEYS,
  parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES,
  parameter int CNT_W               = DEF_CNT_W
) (
  input  logic              clk_50MHz,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] key_n,
  input  logic [N_KEYS-1:0] repeat_en,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_act
);

  for (genvar i = 0; i < N_KEYS; i++) begin : gen_ch
    key_channel #(
      .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES),
      .CNT_W              (CNT_W)
    ) u_ch (
      .clk_50MHz  (clk_50MHz),
      .reset_n    (reset_n),
      .key_n      (key_n[i]),
      .repeat_en  (repeat_en[i]),
      .key_level  (key_level[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_act    (key_act[i])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short timing: debounce 4, repeat delay 10, rate 3.
module tb_key_conditioner;

  localparam int NK = 4;

  logic          clk_50MHz;
  logic          reset_n;
  logic [NK-1:0] key_n;
  logic [NK-1:0] repeat_en;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] key_act;

  key_conditioner #(
    .N_KEYS             (NK),
    .DEBOUNCE_CYCLES    (4),
    .REPEAT_DELAY_CYCLES(10),
    .REPEAT_RATE_CYCLES (3),
    .CNT_W              (26)
  ) dut (
    .clk_50MHz  (clk_50MHz),
    .reset_n    (reset_n),
    .key_n      (key_n),
    .repeat_en  (repeat_en),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_act    (key_act)
  );

  initial clk_50MHz = 1'b0;
  always #5 clk_50MHz = ~clk_50MHz;

  typedef struct {
    string         name;
    int            n;
    logic [NK-1:0] kn;
    logic [NK-1:0] en;
    logic          rst_n;
    logic [NK-1:0] lvl;
    logic [NK-1:0] prs;
    logic [NK-1:0] rls;
    logic [NK-1:0] act;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   act_cnt[NK];
  int   press_cnt[NK];
  int   rel_cnt[NK];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
    end
  endtask

  task automatic clear_counts();
    for (int k = 0; k < NK; k++) begin
      act_cnt[k]   = 0;
      press_cnt[k] = 0;
      rel_cnt[k]   = 0;
    end
  endtask

  // One rising edge, then sample 1 ns later and accumulate pulse counts.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_50MHz);
      #1;
      for (int k = 0; k < NK; k++) begin
        act_cnt[k]   += int'(key_act[k]);
        press_cnt[k] += int'(key_press[k]);
        rel_cnt[k]   += int'(key_release[k]);
      end
      check("press_release_exclusive", 32'(key_press & key_release), 32'd0);
    end
  endtask

  function automatic void add_vec(input string name, input int n, input logic [NK-1:0] kn,
                                  input logic [NK-1:0] en, input logic rst_n,
                                  input logic [NK-1:0] lvl, input logic [NK-1:0] prs,
                                  input logic [NK-1:0] rls, input logic [NK-1:0] act);
    vec_t v;
    v.name = name; v.n = n; v.kn = kn; v.en = en; v.rst_n = rst_n;
    v.lvl = lvl; v.prs = prs; v.rls = rls; v.act = act;
    vecs.push_back(v);
  endfunction

  initial begin
    reset_n   = 1'b0;
    key_n     = 4'b1111;
    repeat_en = 4'b0000;
    clear_counts();

    //       name            n   key_n    rep_en  rst   level    press    release  act
    add_vec("reset",          3, 4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add_vec("idle",           2, 4'b1111, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add_vec("k1_press_e5",    6, 4'b1101, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add_vec("k1_press_e6",    1, 4'b1101, 4'b0000, 1'b1, 4'b0010, 4'b0010, 4'b0000, 4'b0010);
    add_vec("k1_press_e7",    1, 4'b1101, 4'b0000, 1'b1, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    add_vec("k1_hold",       33, 4'b1101, 4'b0000, 1'b1, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    add_vec("k1_rel_e5",      6, 4'b1111, 4'b0000, 1'b1, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    add_vec("k1_rel_e6",      1, 4'b1111, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    add_vec("k1_rel_e7",      1, 4'b1111, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add_vec("sim_press_e5",   6, 4'b1001, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    add_vec("sim_press_e6",   1, 4'b1001, 4'b0000, 1'b1, 4'b0110, 4'b0110, 4'b0000, 4'b0110);
    add_vec("sim_press_e7",   1, 4'b1001, 4'b0000, 1'b1, 4'b0110, 4'b0000, 4'b0000, 4'b0000);
    add_vec("sim_rel1_e5",    6, 4'b1011, 4'b0000, 1'b1, 4'b0110, 4'b0000, 4'b0000, 4'b0000);
    add_vec("sim_rel1_e6",    1, 4'b1011, 4'b0000, 1'b1, 4'b0100, 4'b0000, 4'b0010, 4'b0000);
    add_vec("sim_rel2_e5",    6, 4'b1111, 4'b0000, 1'b1, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
    add_vec("sim_rel2_e6",    1, 4'b1111, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0100, 4'b0000);
    add_vec("sim_settle",     2, 4'b1111, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    for (int v = 0; v < vecs.size(); v++) begin
      key_n     = vecs[v].kn;
      repeat_en = vecs[v].en;
      reset_n   = vecs[v].rst_n;
      step(vecs[v].n);
      check({vecs[v].name, ".level"},   32'(key_level),   32'(vecs[v].lvl));
      check({vecs[v].name, ".press"},   32'(key_press),   32'(vecs[v].prs));
      check({vecs[v].name, ".release"}, 32'(key_release), 32'(vecs[v].rls));
      check({vecs[v].name, ".act"},     32'(key_act),     32'(vecs[v].act));
    end
    check("table_k1_act_count",   32'(act_cnt[1]),   32'd2);
    check("table_k1_press_count", 32'(press_cnt[1]), 32'd2);
    check("table_k1_rel_count",   32'(rel_cnt[1]),   32'd2);
    check("table_k2_act_count",   32'(act_cnt[2]),   32'd1);

    // Bounce: key 0 toggles every 2 cycles, never stable long enough.
    clear_counts();
    for (int i = 0; i < 20; i++) begin
      key_n[0] = ((i / 2) % 2) == 1;
      step(1);
      check("bounce_level", 32'(key_level[0]), 32'd0);
    end
    key_n[0] = 1'b1;
    step(8);
    check("bounce_press_count", 32'(press_cnt[0]), 32'd0);
    check("bounce_act_count",   32'(act_cnt[0]),   32'd0);

    // Glitch of DEBOUNCE_CYCLES-1 is filtered; DEBOUNCE_CYCLES is accepted.
    key_n[0] = 1'b0; step(3);
    key_n[0] = 1'b1; step(10);
    check("glitch3_press_count", 32'(press_cnt[0]), 32'd0);
    key_n[0] = 1'b0; step(4);
    key_n[0] = 1'b1; step(2);
    check("pulse4_level_e5", 32'(key_level[0]), 32'd0);
    step(1);
    check("pulse4_level_e6", 32'(key_level[0]), 32'd1);
    check("pulse4_press_e6", 32'(key_press[0]), 32'd1);
    step(3);
    check("pulse4_level_e9", 32'(key_level[0]), 32'd1);
    step(1);
    check("pulse4_level_e10",  32'(key_level[0]),   32'd0);
    check("pulse4_release_e10", 32'(key_release[0]), 32'd1);
    step(3);
    check("pulse4_press_count", 32'(press_cnt[0]), 32'd1);
    check("pulse4_rel_count",   32'(rel_cnt[0]),   32'd1);

    // Auto-repeat on key 2: acts at 6, 16, 19, ...; release sampled at 40 ends it at 46.
    clear_counts();
    repeat_en = 4'b0100;
    for (int e = 0; e < 56; e++) begin
      logic exp_act;
      key_n[2] = (e >= 40);
      step(1);
      exp_act = (e == 6) || (e >= 16 && e < 46 && ((e - 16) % 3) == 0);
      check("repeat_act", 32'(key_act[2]), 32'(exp_act));
    end
    check("repeat_rel_count", 32'(rel_cnt[2]), 32'd1);
    check("repeat_act_count", 32'(act_cnt[2]), 32'd11);

    // Reset mid-hold on key 3: reset sampled at edges 11 and 12, fresh press at 19.
    repeat_en = 4'b1000;
    for (int e = 0; e <= 40; e++) begin
      logic exp_act;
      logic exp_lvl;
      key_n[3] = 1'b0;
      reset_n  = !(e == 11 || e == 12);
      step(1);
      exp_act = (e == 6) || (e == 19) || (e >= 29 && ((e - 29) % 3) == 0);
      exp_lvl = (e >= 6 && e < 11) || (e >= 19);
      check("rst_hold_act",   32'(key_act[3]),   32'(exp_act));
      check("rst_hold_level", 32'(key_level[3]), 32'(exp_lvl));
      if (e == 11 || e == 12)
        check("rst_hold_all_zero", 32'({key_level, key_press, key_release, key_act}), 32'd0);
    end
    reset_n  = 1'b1;
    key_n[3] = 1'b1;
    step(8);
    check("rst_hold_released", 32'(key_level), 32'd0);

    // repeat_en drop on key 2 sampled 25..36 (would have acted at 25); re-enable acts at 46.
    for (int e = 0; e < 56; e++) begin
      logic exp_act;
      key_n[2]  = 1'b0;
      repeat_en = (e >= 25 && e <= 36) ? 4'b0000 : 4'b0100;
      step(1);
      exp_act = (e == 6) || (e >= 16 && e < 25 && ((e - 16) % 3) == 0) ||
                (e >= 46 && ((e - 46) % 3) == 0);
      check("toggle_act", 32'(key_act[2]), 32'(exp_act));
    end
    key_n     = 4'b1111;
    repeat_en = 4'b0000;
    step(8);
    check("final_idle", 32'({key_level, key_press, key_release, key_act}), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
